rll_deframer: RTL and testbench

RLL_DEFRAMER -- requirements
Module: rll_deframer

---
 rtl/rll_pkg.sv | 15 +
 rtl/rll_bit_deser.sv | 43 ++++
 rtl/rll_deframer.sv | 165 ++++++++++++++++
 tb/tb_rll_deframer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rll_pkg.sv
// Shared types and constants for the RLL deframer: FSM states, default sync
// pattern and byte geometry.
package rll_pkg;

   localparam int          BYTE_W       = 8;
   localparam int          CNT_W        = $clog2(BYTE_W);
   localparam logic [7:0]  SYNC_DEFAULT = 8'hB8;

   typedef enum logic [1:0] {
      HUNT  = 2'd0,
      DATA  = 2'd1,
      CHECK = 2'd2
   } state_t;

endpackage

// File: rtl/rll_bit_deser.sv
// Serial-to-parallel front end: 8-bit MSB-first shift window plus a bit
// counter that flags the edge consuming the last bit of a byte.
module rll_bit_deser
   import rll_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              bit_in,
   input  logic              bit_valid,
   output logic [BYTE_W-1:0] word_nxt,
   output logic              last_bit
);

   logic [BYTE_W-1:0] sr_q, sr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   // word_nxt is the window including the bit being consumed this edge
   always_comb begin
      word_nxt = {sr_q[BYTE_W-2:0], bit_in};
      last_bit = bit_valid && (cnt_q == CNT_W'(BYTE_W - 1));
      sr_d     = sr_q;
      cnt_d    = cnt_q;
      if (clr) begin
         sr_d  = '0;
         cnt_d = '0;
      end else if (bit_valid) begin
         sr_d  = word_nxt;
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else begin
         sr_q  <= sr_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/rll_deframer.sv
// Frame aligner for the RLL decoder bit stream: hunts for the sync word,
// delivers payload bytes and flywheels over up to MISS_MAX-1 bad syncs.
// Optional statistics counters are enabled with RLL_DEFRAMER_STATS_EN.
//
// state | meaning
// HUNT  | searching every bit position for SYNC_WORD, unlocked
// DATA  | locked, assembling FRAME_BYTES payload bytes
// CHECK | locked, collecting the expected sync word
module rll_deframer
   import rll_pkg::*;
#(
   parameter logic [7:0] SYNC_WORD   = SYNC_DEFAULT,
   parameter int         FRAME_BYTES = 4,
   parameter int         MISS_MAX    = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              bit_in,
   input  logic              bit_valid,
   output logic [BYTE_W-1:0] byte_out,
   output logic              byte_valid,
   output logic              locked,
   output logic              sync_err
`ifdef RLL_DEFRAMER_STATS_EN
   ,
   output logic [15:0]       frame_cnt,
   output logic [15:0]       err_cnt
`endif
);

   state_t            state_q, state_d;
   logic [7:0]        byte_cnt_q, byte_cnt_d;
   logic [3:0]        miss_cnt_q, miss_cnt_d;
   logic [BYTE_W-1:0] byte_out_q, byte_out_d;
   logic              byte_valid_q, byte_valid_d;
   logic              locked_q, locked_d;
   logic              sync_err_q, sync_err_d;
   logic              deser_clr;
   logic              good_sync;
   logic [BYTE_W-1:0] word_nxt;
   logic              last_bit;

   rll_bit_deser u_deser (
      .clk       (clk),
      .rst       (rst),
      .clr       (deser_clr),
      .bit_in    (bit_in),
      .bit_valid (bit_valid),
      .word_nxt  (word_nxt),
      .last_bit  (last_bit)
   );

   always_comb begin
      state_d      = state_q;
      byte_cnt_d   = byte_cnt_q;
      miss_cnt_d   = miss_cnt_q;
      byte_out_d   = byte_out_q;
      byte_valid_d = 1'b0;
      locked_d     = locked_q;
      sync_err_d   = 1'b0;
      deser_clr    = 1'b0;
      good_sync    = 1'b0;
      if (bit_valid) begin
         case (state_q)
            HUNT: begin
               if (word_nxt == SYNC_WORD) begin
                  state_d    = DATA;
                  locked_d   = 1'b1;
                  byte_cnt_d = '0;
                  deser_clr  = 1'b1;
                  good_sync  = 1'b1;
               end
            end
            DATA: begin
               if (last_bit) begin
                  byte_out_d   = word_nxt;
                  byte_valid_d = 1'b1;
                  if (byte_cnt_q == 8'(FRAME_BYTES - 1)) begin
                     byte_cnt_d = '0;
                     state_d    = CHECK;
                  end else begin
                     byte_cnt_d = byte_cnt_q + 8'd1;
                  end
               end
            end
            CHECK: begin
               if (last_bit) begin
                  if (word_nxt == SYNC_WORD) begin
                     miss_cnt_d = '0;
                     state_d    = DATA;
                     good_sync  = 1'b1;
                  end else begin
                     sync_err_d = 1'b1;
                     // miss_cnt restarts so a later re-acquisition gets the full budget
                     if (miss_cnt_q + 4'd1 == 4'(MISS_MAX)) begin
                        miss_cnt_d = '0;
                        state_d    = HUNT;
                        locked_d   = 1'b0;
                        deser_clr  = 1'b1;
                     end else begin
                        miss_cnt_d = miss_cnt_q + 4'd1;
                        state_d    = DATA;
                     end
                  end
               end
            end
            default: begin
               state_d  = HUNT;
               locked_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= HUNT;
         byte_cnt_q   <= '0;
         miss_cnt_q   <= '0;
         byte_out_q   <= '0;
         byte_valid_q <= 1'b0;
         locked_q     <= 1'b0;
         sync_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         byte_cnt_q   <= byte_cnt_d;
         miss_cnt_q   <= miss_cnt_d;
         byte_out_q   <= byte_out_d;
         byte_valid_q <= byte_valid_d;
         locked_q     <= locked_d;
         sync_err_q   <= sync_err_d;
      end
   end

   assign byte_out   = byte_out_q;
   assign byte_valid = byte_valid_q;
   assign locked     = locked_q;
   assign sync_err   = sync_err_q;

`ifdef RLL_DEFRAMER_STATS_EN
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic [15:0] err_cnt_q, err_cnt_d;

   always_comb begin
      frame_cnt_d = frame_cnt_q;
      err_cnt_d   = err_cnt_q;
      if (good_sync && frame_cnt_q != 16'hFFFF) frame_cnt_d = frame_cnt_q + 16'd1;
      if (sync_err_d && err_cnt_q != 16'hFFFF)  err_cnt_d   = err_cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cnt_q <= '0;
         err_cnt_q   <= '0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign frame_cnt = frame_cnt_q;
   assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_rll_deframer.sv
// Self-checking bench for rll_deframer: directed scenarios plus randomized
// streams, all checked against a frame-position model of the bit stream.
module tb_rll_deframer;

   localparam logic [7:0] SYNC      = 8'hB8;
   localparam int         FB        = 4;
   localparam int         MM        = 2;
   localparam int         FRAME_LEN = 8 * FB + 8;
   localparam int         MAXB      = 512;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       bit_in = 1'b0;
   logic       bit_valid = 1'b0;
   logic [7:0] byte_out;
   logic       byte_valid;
   logic       locked;
   logic       sync_err;
`ifdef RLL_DEFRAMER_STATS_EN
   logic [15:0] frame_cnt;
   logic [15:0] err_cnt;
`endif

   rll_deframer #(
      .SYNC_WORD   (SYNC),
      .FRAME_BYTES (FB),
      .MISS_MAX    (MM)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bit_in     (bit_in),
      .bit_valid  (bit_valid),
      .byte_out   (byte_out),
      .byte_valid (byte_valid),
      .locked     (locked),
      .sync_err   (sync_err)
`ifdef RLL_DEFRAMER_STATS_EN
      ,
      .frame_cnt  (frame_cnt),
      .err_cnt    (err_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic       seg_bits[$];
   bit         exp_bv[MAXB];
   logic [7:0] exp_byte[MAXB];
   bit         exp_err[MAXB];
   bit         exp_lock[MAXB];
   int         obs_bv;
   int         obs_err;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic push_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) seg_bits.push_back(b[i]);
   endtask

   // 8-bit window ending at bit k; bits before index s read as zero (cleared window)
   function automatic logic [7:0] win(input int k, input int s);
      logic [7:0] w;
      int idx;
      w = '0;
      for (int b = 0; b < 8; b++) begin
         idx = k - 7 + b;
         w[7-b] = (idx >= s && idx >= 0) ? seg_bits[idx] : 1'b0;
      end
      return w;
   endfunction

   // Frames are located arithmetically from each acquisition point.
   task automatic build_model();
      int n, s, p, miss, base, e, c;
      bit done;
      n = seg_bits.size();
      for (int k = 0; k < MAXB; k++) begin
         exp_bv[k] = 0; exp_byte[k] = '0; exp_err[k] = 0; exp_lock[k] = 0;
      end
      s = 0;
      done = 0;
      while (!done) begin
         p = -1;
         for (int k = s; k < n; k++) begin
            if (win(k, s) == SYNC) begin p = k; break; end
         end
         if (p < 0) done = 1;
         else begin
            for (int k = p; k < n; k++) exp_lock[k] = 1;
            miss = 0;
            for (int f = 0; !done; f++) begin
               base = p + f * FRAME_LEN;
               for (int j = 0; j < FB; j++) begin
                  e = base + 8 * (j + 1);
                  if (e < n) begin exp_bv[e] = 1; exp_byte[e] = win(e, 0); end
               end
               c = base + FRAME_LEN;
               if (c >= n) done = 1;
               else if (win(c, 0) == SYNC) miss = 0;
               else begin
                  exp_err[c] = 1;
                  miss++;
                  if (miss == MM) begin
                     for (int k = c; k < n; k++) exp_lock[k] = 0;
                     s = c + 1;
                     break;
                  end
               end
            end
         end
      end
   endtask

   // gap_mode: 0 continuous, 1 idle cycle before every bit, 2 random idles
   task automatic run_seg(input int gap_mode);
      int n, ng;
      logic       cur_lock;
      logic [7:0] cur_byte;
      build_model();
      n = seg_bits.size();
      cur_lock = 1'b0;
      cur_byte = 8'h00;
      obs_bv = 0;
      obs_err = 0;
      for (int k = 0; k < n; k++) begin
         ng = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
         repeat (ng) begin
            bit_valid = 1'b0;
            bit_in = 1'bz;
            @(posedge clk); #1;
            check("gap_byte_valid", 16'(byte_valid), 16'd0);
            check("gap_sync_err", 16'(sync_err), 16'd0);
            check("gap_locked", 16'(locked), 16'(cur_lock));
            check("gap_byte_hold", 16'(byte_out), 16'(cur_byte));
         end
         bit_valid = 1'b1;
         bit_in = seg_bits[k];
         @(posedge clk); #1;
         cur_lock = exp_lock[k];
         if (exp_bv[k]) cur_byte = exp_byte[k];
         check("byte_valid", 16'(byte_valid), 16'(exp_bv[k]));
         check("byte_out", 16'(byte_out), 16'(cur_byte));
         check("sync_err", 16'(sync_err), 16'(exp_err[k]));
         check("locked", 16'(locked), 16'(cur_lock));
         if (byte_valid) obs_bv++;
         if (sync_err) obs_err++;
      end
      bit_valid = 1'b0;
      bit_in = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bit_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_byte_out", 16'(byte_out), 16'h00);
      check("rst_byte_valid", 16'(byte_valid), 16'd0);
      check("rst_locked", 16'(locked), 16'd0);
      check("rst_sync_err", 16'(sync_err), 16'd0);
`ifdef RLL_DEFRAMER_STATS_EN
      check("rst_frame_cnt", frame_cnt, 16'd0);
      check("rst_err_cnt", err_cnt, 16'd0);
`endif
      rst = 1'b0;
   endtask

   task automatic acquire_stream();
      seg_bits.delete();
      push_byte(SYNC);
      push_byte(8'h12); push_byte(8'h34); push_byte(8'h56); push_byte(8'h78);
   endtask

   initial begin
      // acquire
      do_reset();
      acquire_stream();
      run_seg(0);
      check("acq_strobes", 16'(obs_bv), 16'd4);
      check("acq_locked", 16'(locked), 16'd1);

      // flywheel over one bad sync
      do_reset();
      seg_bits.delete();
      push_byte(SYNC);
      push_byte(8'h12); push_byte(8'h34); push_byte(8'h56); push_byte(8'h78);
      push_byte(8'h00);
      push_byte(8'h9A); push_byte(8'hBC); push_byte(8'hDE); push_byte(8'hF0);
      push_byte(SYNC);
      run_seg(0);
      check("fly_strobes", 16'(obs_bv), 16'd8);
      check("fly_errs", 16'(obs_err), 16'd1);
      check("fly_locked", 16'(locked), 16'd1);
`ifdef RLL_DEFRAMER_STATS_EN
      check("fly_frame_cnt", frame_cnt, 16'd2);
      check("fly_err_cnt", err_cnt, 16'd1);
`endif

      // loss of lock after two bad syncs
      do_reset();
      seg_bits.delete();
      push_byte(SYNC);
      push_byte(8'h12); push_byte(8'h34); push_byte(8'h56); push_byte(8'h78);
      push_byte(8'h00);
      push_byte(8'h9A); push_byte(8'hBC); push_byte(8'hDE); push_byte(8'hF0);
      push_byte(8'h00);
      push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
      run_seg(0);
      check("loss_strobes", 16'(obs_bv), 16'd8);
      check("loss_errs", 16'(obs_err), 16'd2);
      check("loss_locked", 16'(locked), 16'd0);
`ifdef RLL_DEFRAMER_STATS_EN
      check("loss_frame_cnt", frame_cnt, 16'd1);
      check("loss_err_cnt", err_cnt, 16'd2);
`endif

      // gaps every other cycle
      do_reset();
      acquire_stream();
      run_seg(1);
      check("gap_strobes", 16'(obs_bv), 16'd4);

      // reset after 5 payload bits, then re-acquire
      do_reset();
      seg_bits.delete();
      push_byte(SYNC);
      for (int i = 7; i >= 3; i--) seg_bits.push_back(i == 4);
      run_seg(0);
      check("mid_locked_before", 16'(locked), 16'd1);
      rst = 1'b1;
      bit_valid = 1'b1;
      bit_in = 1'b1;
      @(posedge clk); #1;
      check("mid_rst_byte_valid", 16'(byte_valid), 16'd0);
      check("mid_rst_locked", 16'(locked), 16'd0);
      check("mid_rst_byte_out", 16'(byte_out), 16'h00);
      rst = 1'b0;
      bit_valid = 1'b0;
      @(posedge clk); #1;
      check("mid_idle_byte_valid", 16'(byte_valid), 16'd0);
      acquire_stream();
      run_seg(0);
      check("reacq_strobes", 16'(obs_bv), 16'd4);

      // randomized streams with occasional corrupted syncs
      for (int r = 0; r < 8; r++) begin
         do_reset();
         seg_bits.delete();
         repeat ($urandom_range(0, 20)) seg_bits.push_back(1'($urandom_range(0, 1)));
         push_byte(SYNC);
         for (int f = 0; f < 6; f++) begin
            for (int j = 0; j < FB; j++) push_byte(8'($urandom));
            push_byte(($urandom_range(0, 3) == 0) ? 8'($urandom) : SYNC);
         end
         run_seg(2);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
